aes128_decrypt_iter: RTL and testbench



---
 rtl/aes128_decrypt_iter.sv | 246 ++++++++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter
// Iterative AES-128 inverse cipher. It performs one round per clock and
// derives the round keys on the fly. A forward key expansion walks from the
// cipher key to rk10. The rounds then run the key schedule backwards to rk0.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   in_valid      ciphertext/key present
//   in_ready      engine can accept a request (high only in IDLE)
//   cipher_in     ciphertext, bits [127:120] = byte 0 (column-major)
//   key_in        AES-128 cipher key, same byte order
//   out_valid     plaintext_out valid (high only in DONE)
//   out_ready     consumer accepts plaintext
//   plaintext_out decrypted block, same byte order, held while in DONE
//   busy          high in any state other than IDLE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer keeps valid and data stable until that edge.
// in_ready and out_valid are never high together, so consecutive results
// are always separated by a one-cycle bubble.
//
// KEY_CACHE=1 keeps the cipher key and its rk10 after each expansion. A
// request that uses the same key then starts directly at INIT.
module aes128_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext_out,
    output logic         busy
);

    // Forward S-box. Byte 0 sits in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // The inverse table is built at elaboration by inverting SBOX. This
    // keeps the two tables consistent by construction.
    function automatic logic [2047:0] makeInvSbox();
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 256; i++)
            t[2047 - 8*int'(SBOX[2047 - 8*i -: 8]) -: 8] = 8'(i);
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX = makeInvSbox();

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return INV_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 24'h0}
    function automatic logic [31:0] gFunc(input logic [31:0] w, input logic [7:0] rc);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]) ^ rc, sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [127:0] fwdStep(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ gFunc(k[31:0], rc);
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undoes fwdStep. w3 is recovered first because the old w0 depends on
    // SubWord of the old w3.
    function automatic logic [127:0] revStep(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ gFunc(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows followed by InvSubBytes. Row r is rotated right by r.
    function automatic logic [127:0] invShiftSub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = invSbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0] x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]   = s[127 - 8*(r + 4*c) -: 8];
                x2     = xtime(a[r]);
                x4     = xtime(x2);
                x8     = xtime(x4);
                m9[r]  = x8 ^ a[r];
                m11[r] = x8 ^ x2 ^ a[r];
                m13[r] = x8 ^ x4 ^ a[r];
                m14[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 32*c -: 8]  = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
            o[119 - 32*c -: 8]  = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
            o[111 - 32*c -: 8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
            o[103 - 32*c -: 8]  = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
        end
        return o;
    endfunction

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, LAST, DONE} state_t;

    state_t       state, nextState;
    logic [127:0] stateReg, keyReg, cacheKey, cacheRk, plainReg;
    logic [3:0]   roundCnt;
    logic         cacheValid;
    logic         cacheHit;
    logic [127:0] fwdKey, revKey, roundOut;

    assign cacheHit = (KEY_CACHE != 0) && cacheValid && (key_in == cacheKey);

    // In ROUND the counter holds r (9..1), so rk_r needs rcon[r+1]. LAST
    // runs with the counter at 0 and therefore uses rcon[1] for rk0.
    assign fwdKey   = fwdStep(keyReg, rcon(roundCnt));
    assign revKey   = revStep(keyReg, rcon(roundCnt + 4'd1));
    assign roundOut = invShiftSub(stateReg) ^ revKey;

    assign plaintext_out = plainReg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = cacheHit ? INIT : KEYEXP;
            end
            KEYEXP:  if (roundCnt == 4'd10) nextState = INIT;
            INIT:    nextState = ROUND;
            ROUND:   if (roundCnt == 4'd1) nextState = LAST;
            LAST:    nextState = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= '0;
            keyReg     <= '0;
            cacheKey   <= '0;
            cacheRk    <= '0;
            plainReg   <= '0;
            roundCnt   <= '0;
            cacheValid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    stateReg <= cipher_in;
                    if (cacheHit) begin
                        keyReg <= cacheRk;
                    end else begin
                        keyReg     <= key_in;
                        roundCnt   <= 4'd1;
                        cacheKey   <= key_in;
                        cacheValid <= 1'b0;
                    end
                end
                KEYEXP: begin
                    keyReg <= fwdKey;
                    if (roundCnt == 4'd10) begin
                        cacheRk    <= fwdKey;
                        cacheValid <= 1'b1;
                    end else begin
                        roundCnt <= roundCnt + 4'd1;
                    end
                end
                INIT: begin
                    stateReg <= stateReg ^ keyReg;
                    roundCnt <= 4'd9;
                end
                ROUND: begin
                    keyReg   <= revKey;
                    stateReg <= invMixColumns(roundOut);
                    roundCnt <= roundCnt - 4'd1;
                end
                LAST:    plainReg <= roundOut;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter. A driver issues requests and pushes the
// expected plaintext and latency into queues. A negedge monitor pops the
// queues and compares them with every result the engine presents. Random
// expectations come from a forward AES-128 encryptor written on byte arrays.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] cipher_in, key_in, plaintext_out;

    aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_in(cipher_in), .key_in(key_in), .out_valid(out_valid),
        .out_ready(out_ready), .plaintext_out(plaintext_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [127:0] expQ[$];
    int           latQ[$];
    int           accQ[$];
    logic [7:0]   sb [256];
    logic         tbCacheValid = 1'b0;
    logic [127:0] tbCacheKey = '0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] y, input int n);
        logic [15:0] d;
        d = {y, y};
        return d[15 - n -: 8];
    endfunction

    // S-box from its definition: the GF(2^8) inverse followed by the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aesEnc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: the first cycle of each result pops and checks data and
    // latency. Later cycles check that the result is held.
    logic         pending = 1'b0;
    logic [127:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 1'b0);
            if (!pending) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_output", plaintext_out, 128'h0 ^ ~plaintext_out);
                end else begin
                    chk("plaintext", plaintext_out, expQ.pop_front());
                    chkInt("latency", cyc - accQ.pop_front(), latQ.pop_front());
                end
                held = plaintext_out;
                pending = 1'b1;
            end else begin
                chk("plaintext_held", plaintext_out, held);
            end
            if (out_ready) pending = 1'b0;
        end
    end

    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p, input bit hold);
        int n;
        int lat;
        n = 0;
        cipher_in = c;
        key_in    = k;
        in_valid  = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            chkInt("accept_timeout", n, 0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        lat = (tbCacheValid && k == tbCacheKey) ? 11 : 21;
        if (lat == 21) begin
            tbCacheValid = 1'b1;
            tbCacheKey   = k;
        end
        expQ.push_back(p);
        latQ.push_back(lat);
        accQ.push_back(cyc);
        if (!hold) in_valid = 1'b0;
        cipher_in = rand128();
        key_in    = rand128();
    endtask

    task automatic sendRandom(input logic [127:0] k, input bit hold);
        logic [127:0] p;
        p = rand128();
        send(aesEnc(p, k), k, p, hold);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || out_valid || expQ.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chkInt("idle_timeout", n, 0);
    endtask

    initial begin
        logic [127:0] k0, poolA, poolB;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cipher_in = '0; key_in = '0;
        buildSbox();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_plaintext", plaintext_out, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS vectors, then a cache hit on a repeated key.
        send(C1_CT, C1_KEY, C1_PT, 1'b0); waitIdle();
        send(B_CT, B_KEY, B_PT, 1'b0);    waitIdle();
        chk("rk10_app_b", dut.cacheRk, B_RK10);
        send(B_CT, B_KEY, B_PT, 1'b0);    waitIdle();
        send(C1_CT, C1_KEY, C1_PT, 1'b0); waitIdle();

        // Backpressure while a cache-hit result waits.
        out_ready = 1'b0;
        send(C1_CT, C1_KEY, C1_PT, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_rise", out_valid, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("bp_out_valid_held", out_valid, 1'b1);
            chk("bp_in_ready_low", in_ready, 1'b0);
            if (i == 2) begin
                in_valid = 1'b1; cipher_in = rand128(); key_in = rand128();
            end
            if (i == 4) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", out_valid, 1'b0);
        chk("bp_release_in_ready", in_ready, 1'b1);
        waitIdle();

        // Reset at E15 of a C.1 request that needs a full expansion.
        sendRandom(rand128(), 1'b0); waitIdle();
        send(C1_CT, C1_KEY, C1_PT, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete(); latQ.delete(); accQ.delete();
        tbCacheValid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_plaintext", plaintext_out, 128'h0);
        in_valid = 1'b1; cipher_in = rand128(); key_in = rand128();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_beats_in_valid", busy, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        send(B_CT, B_KEY, B_PT, 1'b0); waitIdle();

        // Back-to-back with in_valid held high.
        k0 = rand128();
        sendRandom(k0, 1'b1);
        sendRandom(k0, 1'b1);
        sendRandom(rand128(), 1'b1);
        send(aesEnc(B_PT ^ 128'h1, C1_KEY), C1_KEY, B_PT ^ 128'h1, 1'b0);
        waitIdle();

        // Random traffic drawn from a small key pool so hits and misses mix.
        poolA = rand128(); poolB = rand128();
        for (int i = 0; i < 8; i++) begin
            sendRandom(($urandom_range(0, 1) == 0) ? poolA : poolB, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        waitIdle();
        chkInt("queue_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
